// File: rtl/dsp48a1_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp48a1_mac_sequencer
//  Purpose  : Sequences one DSP48A1 slice through signed multiply-accumulate
//             runs (dot product of N pairs of 18-bit operands, 48-bit result).
//             The slice is expected to be configured with A0REG=B0REG=0,
//             A1REG=B1REG=CREG=DREG=MREG=PREG=OPMODEREG=1, B_INPUT="DIRECT",
//             CARRYINSEL="OPMODE5". The sequencer tracks the three-stage
//             A1/B1 -> M -> P pipeline and returns P on a valid/ready port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, RSTN            clock / asynchronous active-low reset
//    start, len, abort    run command (len sampled with start), cancel
//    busy                 high whenever not idle
//    s_valid/s_ready      operand stream handshake, s_a / s_b operands
//    res_valid/res_ready  result handshake, res_data accumulated result
//    DSP_*                slice data, OPMODE, clock-enable and reset drives;
//                         DSP_P is the slice P output
// ============================================================================
module dsp48a1_mac_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [17:0]      DSP_D,
  output logic [47:0]      DSP_C,
  output logic [17:0]      DSP_BCIN,
  output logic [47:0]      DSP_PCIN,
  output logic             DSP_CARRYIN,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CEA,
  output logic             DSP_CEB,
  output logic             DSP_CEM,
  output logic             DSP_CEOPMODE,
  output logic             DSP_CEP,
  output logic             DSP_CEC,
  output logic             DSP_CED,
  output logic             DSP_CECARRYIN,
  output logic             DSP_RST,
  input  logic [47:0]      DSP_P
);

  // X=M, Z=0: first product of a run overwrites P, so no slice reset is
  // needed between runs.
  localparam logic [7:0] OPM_FIRST = 8'h01;
  // X=M, Z=P: accumulate onto the running P.
  localparam logic [7:0] OPM_ACC   = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [7:0]       opmode_q, opmode_d;
  logic [47:0]      res_data_q, res_data_d;
  logic             dsp_rst_q, dsp_rst_d;

  logic             abort_act;
  logic             ready;
  logic             beat;

  // abort only has an effect outside IDLE (start wins in IDLE).
  assign abort_act = abort && (state_q != ST_IDLE);
  assign ready     = (state_q == ST_RUN) && (remaining_q != '0) && !abort_act;
  assign beat      = s_valid && ready;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      opmode_q    <= 8'h00;
      res_data_q  <= '0;
      // Held high through reset and for the cycle up to the first edge
      // after release, so the slice is cleared by its synchronous resets.
      dsp_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      opmode_q    <= opmode_d;
      res_data_q  <= res_data_d;
      dsp_rst_q   <= dsp_rst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    v1_d        = beat;
    v2_d        = v1_q;
    opmode_d    = opmode_q;
    res_data_d  = res_data_q;
    dsp_rst_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            remaining_d = len;
            first_d     = 1'b1;
            state_d     = ST_RUN;
          end else begin
            res_data_d  = '0;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_RUN: begin
        if (beat) begin
          remaining_d = remaining_q - LEN_W'(1);
          first_d     = 1'b0;
          // Registered with the beat; the slice latches it one edge later
          // alongside M, so it lines up with the product entering P.
          opmode_d    = first_q ? OPM_FIRST : OPM_ACC;
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Both stage-valid bits clear means the last product has already
        // been written into P, so DSP_P is final this cycle.
        if (!v1_q && !v2_q) begin
          res_data_d = DSP_P;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_act) begin
      state_d   = ST_IDLE;
      v1_d      = 1'b0;
      v2_d      = 1'b0;
      dsp_rst_d = 1'b1;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign s_ready   = ready;
  assign res_valid = (state_q == ST_HOLD);
  assign res_data  = res_data_q;

  assign DSP_A         = s_a;
  assign DSP_B         = s_b;
  assign DSP_D         = '0;
  assign DSP_C         = '0;
  assign DSP_BCIN      = '0;
  assign DSP_PCIN      = '0;
  assign DSP_CARRYIN   = 1'b0;
  assign DSP_OPMODE    = opmode_q;

  // Stage enables; an abort silences every stage in the same cycle.
  assign DSP_CEA       = beat;
  assign DSP_CEB       = beat;
  assign DSP_CEM       = v1_q && !abort_act;
  assign DSP_CEOPMODE  = v1_q && !abort_act;
  assign DSP_CEP       = v2_q && !abort_act;
  assign DSP_CEC       = 1'b0;
  assign DSP_CED       = 1'b0;
  assign DSP_CECARRYIN = 1'b0;
  assign DSP_RST       = dsp_rst_q;

endmodule
`default_nettype wire

// File: doc/dsp48a1_mac_sequencer.md
Name: dsp48a1_mac_sequencer

Overview:
- Sequences one DSP48A1 slice through multiply-accumulate runs: dot product of N signed 18-bit operand pairs, 48-bit result.
- Sits between a streaming operand source and a DSP instance configured A0REG=B0REG=0, A1REG=B1REG=CREG=DREG=MREG=PREG=OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".
- Drives the slice's data, OPMODE, clock-enable and reset ports, tracks the 3-stage pipeline (A1/B1 -> M -> P), and returns the accumulated P through a valid/ready result port.

Parameters:
- LEN_W, 16, width of the run-length field; maximum run is 2^LEN_W-1 pairs.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs, sampled with start.
- abort  in  1  synchronous cancel of the current run.
- busy  out  1  high in any state other than IDLE.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  sequencer accepts a pair.
- s_a  in  18  signed operand A.
- s_b  in  18  signed operand B.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_data  out  48  accumulated result.
- DSP_A, DSP_B  out  18  combinational pass-through of s_a and s_b.
- DSP_D  out  18  constant 0.
- DSP_C  out  48  constant 0.
- DSP_BCIN  out  18  constant 0.
- DSP_PCIN  out  48  constant 0.
- DSP_CARRYIN  out  1  constant 0.
- DSP_OPMODE  out  8  registered OPMODE.
- DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP  out  1  per-stage enables.
- DSP_CEC, DSP_CED, DSP_CECARRYIN  out  1  constant 0.
- DSP_RST  out  1  drives all eight slice RST* inputs; registered.
- DSP_P  in  48  slice P output.

Behaviour:
- Reset (RSTN=0), asynchronous:
  - state=IDLE; busy, s_ready, res_valid, all CE outputs = 0.
  - res_data=0; DSP_OPMODE=8'h00.
  - DSP_RST=1, held until the first clock edge after RSTN deasserts, then 0.
- States:
  - IDLE: on start with len>0, load remaining=len and go to RUN. On start with len=0, set res_data=0 and go to HOLD.
  - RUN: s_ready = (remaining>0). A beat is an edge where s_valid & s_ready is high; each beat decrements remaining. After the last beat, go to DRAIN.
  - DRAIN: wait for the pipeline to empty (below), capture DSP_P into res_data, go to HOLD.
  - HOLD: res_valid=1, res_data stable. When res_valid & res_ready, go to IDLE.
- Pipeline tracking, with beat k occurring at edge e:
  - DSP_CEA = DSP_CEB = s_valid & s_ready, so A1/B1 capture at edge e.
  - v1 <= beat; DSP_CEM = DSP_CEOPMODE = v1, so M and the OPMODE register capture at edge e+1.
  - v2 <= v1; DSP_CEP = v2, so P captures at edge e+2.
- OPMODE: registered at edge e from a first-beat flag.
  - First beat of a run: 8'h01 (X=M, Z=0; starts a fresh accumulation, so no slice reset is needed).
  - Later beats: 8'h09 (X=M, Z=P).
  - Pre-adder, carry and subtract bits are always 0.
- Result timing:
  - res_data <= DSP_P at edge L+3, where L is the last beat's edge; res_valid is high from that edge onward.
  - With no input bubbles: an N-pair run occupies N beat edges, and the result is valid 3 edges after the final beat.
- Bubbles: s_valid low in RUN produces no beat, and the CEs for that slot stay low. P is unaffected; the result does not change.
- Arithmetic:
  - 18x18 signed product, 48-bit two's-complement accumulation in the slice.
  - Wrap-around at 48 bits is not detected and is not flagged.
- Commands while busy: start is ignored in RUN, DRAIN and HOLD, and is not queued.
- Abort (any state except IDLE):
  - Next state is IDLE; s_ready and the CE outputs go to 0 the same cycle.
  - DSP_RST pulses high for exactly 1 cycle; v1/v2 are cleared; no result is produced.
  - abort and start in the same IDLE cycle: start wins, abort is ignored.
- RSTN asserted mid-run: immediate return to reset values; the slice is reset via DSP_RST.

Test Plan:
- Bench uses a real slice instance with the parameters above.
- len=4; pairs (1,5),(2,6),(3,7),(4,8) with no bubbles; res_ready=1 -> res_data=48'd70, res_valid for 1 cycle, exactly 3 edges after the 4th beat; busy then 0.
- len=2; pairs (-3,2),(-1,-1) (18'h3FFFD,18'h2 then 18'h3FFFF,18'h3FFFF) -> res_data=48'hFFFF_FFFF_FFFB (-5).
- len=3; s_valid toggled 1,0,0,1,0,1 with pairs (10,10),(20,1),(1,1) -> res_data=121. CEA is low in bubble cycles; DSP_OPMODE=8'h01 only for the first beat.
- len=0 start -> res_valid=1 with res_data=0 on the next edge; no CE ever asserted. Hold res_ready=0 for 5 cycles -> res_valid and res_data stable; a start issued meanwhile is ignored.
- len=5; abort after beat 2 -> one-cycle DSP_RST pulse, IDLE, no res_valid. A following run of len=1 with (7,9) -> 63, with no residue from the aborted run.
- RSTN low for 2 cycles mid-RUN -> all outputs at reset values immediately; after release, a len=1 run with (2,3) -> 6.
